mem_arbiter: RTL and testbench

Arbiter that shares the single-port data memory (ref_clk, WE, DataI/DataO style, one-cycle synchronous read) between the pipeline's instruction-fetch requester and the load/store (memory-stage) requester. Grants one requester per cycle with memory-stage priority and a bounded starvation guard for fetch. Also returns read data with a one-cycle valid pulse, and gives the pipeline buffers a stall signal for the losing requester.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the arbiter's requester-facing and memory-facing signals.
// Ports (all signals are interface members):
//   fetch      : if_req, if_addr -> if_gnt, if_valid, if_rdata, stall_if
//   load/store : ls_req, ls_we, ls_addr, ls_wdata -> ls_gnt, ls_valid,
//                ls_rdata, stall_ls
//   memory     : mem_we, mem_addr, mem_wdata -> mem_rdata
// Modports:
//   slave  - the arbiter side (consumes requests, drives grants and the memory bus)
//   master - the environment side (requesters plus memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              stall_if;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_valid;
  logic [DATA_W-1:0] ls_rdata;
  logic              stall_ls;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, stall_if,
    output ls_gnt, ls_valid, ls_rdata, stall_ls,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, stall_if,
    input  ls_gnt, ls_valid, ls_rdata, stall_ls,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous-read data memory between the
// instruction-fetch requester and the load/store requester. Load/store wins
// contention unless fetch has been denied STARVE_MAX consecutive cycles.
// Read data is returned one cycle after the grant with a one-cycle valid.
// Ports:
//   ref_clk  - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   bus      - mem_arbiter_if.slave: requests, grants, stalls, read
//              responses and the memory address/data/write-enable bus
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic          ref_clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_MAX);

  logic [CntW-1:0]   starveCntQ, starveCntD;
  logic              rdIfQ, rdIfD;
  logic              rdLsQ, rdLsD;
  logic [DATA_W-1:0] ifRdataQ, ifRdataD;
  logic [DATA_W-1:0] lsRdataQ, lsRdataD;
  logic              ifGnt, lsGnt;

  // Grant selection; everything is held off while reset is asserted.
  always_comb begin
    ifGnt = 1'b0;
    lsGnt = 1'b0;
    if (rst_n) begin
      if (bus.if_req && (!bus.ls_req || starveCntQ == StarveLim)) begin
        ifGnt = 1'b1;
      end else if (bus.ls_req) begin
        lsGnt = 1'b1;
      end
    end
  end

  // Memory bus mux: idle cycles present an all-zero bus.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (lsGnt) begin
      bus.mem_we    = bus.ls_we;
      bus.mem_addr  = bus.ls_addr;
      bus.mem_wdata = bus.ls_wdata;
    end else if (ifGnt) begin
      bus.mem_addr  = bus.if_addr;
    end
  end

  // Next-state: starvation counter, read-owner flags, captured read data.
  always_comb begin
    starveCntD = '0;
    if (bus.if_req && !ifGnt) begin
      starveCntD = (starveCntQ == StarveLim) ? starveCntQ : starveCntQ + CntW'(1);
    end
    rdIfD    = ifGnt;
    rdLsD    = lsGnt && !bus.ls_we;
    ifRdataD = rdIfQ ? bus.mem_rdata : ifRdataQ;
    lsRdataD = rdLsQ ? bus.mem_rdata : lsRdataQ;
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCntQ <= '0;
      rdIfQ      <= 1'b0;
      rdLsQ      <= 1'b0;
      ifRdataQ   <= '0;
      lsRdataQ   <= '0;
    end else begin
      starveCntQ <= starveCntD;
      rdIfQ      <= rdIfD;
      rdLsQ      <= rdLsD;
      ifRdataQ   <= ifRdataD;
      lsRdataQ   <= lsRdataD;
    end
  end

  assign bus.if_gnt   = ifGnt;
  assign bus.ls_gnt   = lsGnt;
  assign bus.stall_if = rst_n && bus.if_req && !ifGnt;
  assign bus.stall_ls = rst_n && bus.ls_req && !lsGnt;
  assign bus.if_valid = rdIfQ;
  assign bus.ls_valid = rdLsQ;
  // In the valid cycle the word comes straight from memory; the register
  // captures it at the end of that cycle and holds it afterwards.
  assign bus.if_rdata = ifRdataD;
  assign bus.ls_rdata = lsRdataD;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small synchronous-read memory model
// attached to the memory side of the interface.
module tb_mem_arbiter;

  logic refClk;
  logic rstN;
  int   checkCount;
  int   failCount;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .ref_clk (refClk),
    .rst_n   (rstN),
    .bus     (bus)
  );

  initial refClk = 1'b0;
  always #5 refClk = ~refClk;

  // Single-port memory: write commits at the edge, read data appears the
  // cycle after the address is presented.
  logic [31:0] memArray [0:255];
  always @(posedge refClk) begin
    if (bus.mem_we) memArray[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= memArray[bus.mem_addr[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic lsReq, input logic lsWe,
                               input logic [31:0] lsAddr, input logic [31:0] lsWdata);
    bus.if_req   = ifReq;
    bus.if_addr  = ifAddr;
    bus.ls_req   = lsReq;
    bus.ls_we    = lsWe;
    bus.ls_addr  = lsAddr;
    bus.ls_wdata = lsWdata;
  endtask

  task automatic nextCycle();
    @(posedge refClk);
    #1;
  endtask

  initial begin
    logic prevIfWin;
    checkCount = 0;
    failCount  = 0;
    rstN = 1'b0;
    prevIfWin = 1'b0;

    // Reset with both requests asserted: ls presents a store of 0x7FF to 0x10.
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h10, 32'h7FF);
    repeat (3) @(posedge refClk);
    #3;
    checkOutput("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("rst_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_stall_if", 32'(bus.stall_if), 32'd0);
    checkOutput("rst_stall_ls", 32'(bus.stall_ls), 32'd0);
    checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("rst_ls_valid", 32'(bus.ls_valid), 32'd0);
    checkOutput("rst_if_rdata", bus.if_rdata, 32'd0);
    checkOutput("rst_ls_rdata", bus.ls_rdata, 32'd0);

    rstN = 1'b1;
    #2;
    checkOutput("rel_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    checkOutput("rel_if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("rel_stall_if", 32'(bus.stall_if), 32'd1);
    checkOutput("rel_mem_we", 32'(bus.mem_we), 32'd1);
    checkOutput("rel_mem_addr", bus.mem_addr, 32'h10);

    // Idle cycle: no grant, zero bus, the store yields no valid.
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("idle_if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("idle_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    checkOutput("idle_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("idle_ls_valid", 32'(bus.ls_valid), 32'd0);

    // Fetch read of 0x10.
    nextCycle();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("fetch_if_gnt", 32'(bus.if_gnt), 32'd1);
    checkOutput("fetch_mem_addr", bus.mem_addr, 32'h10);
    checkOutput("fetch_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("fetch_stall_if", 32'(bus.stall_if), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("fetch_if_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("fetch_if_rdata", bus.if_rdata, 32'h7FF);
    nextCycle();
    #2;
    checkOutput("fetch_if_valid_drop", 32'(bus.if_valid), 32'd0);
    checkOutput("fetch_if_rdata_hold", bus.if_rdata, 32'h7FF);

    // Store 0x20 <- 0x7FF, then load 0x20 the next cycle.
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h7FF);
    #2;
    checkOutput("st_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    checkOutput("st_mem_we", 32'(bus.mem_we), 32'd1);
    checkOutput("st_mem_wdata", bus.mem_wdata, 32'h7FF);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    #2;
    checkOutput("ld_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    checkOutput("ld_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("st_no_ls_valid", 32'(bus.ls_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("ld_ls_valid", 32'(bus.ls_valid), 32'd1);
    checkOutput("ld_ls_rdata", bus.ls_rdata, 32'h7FF);
    nextCycle();
    #2;
    checkOutput("ld_ls_valid_drop", 32'(bus.ls_valid), 32'd0);

    // Starvation: both held 10 cycles, expect LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
    for (int i = 0; i < 10; i++) begin
      logic ifWin;
      ifWin = (i == 4) || (i == 9);
      nextCycle();
      applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
      #2;
      checkOutput($sformatf("starve_if_gnt_%0d", i), 32'(bus.if_gnt), 32'(ifWin));
      checkOutput($sformatf("starve_ls_gnt_%0d", i), 32'(bus.ls_gnt), 32'(!ifWin));
      checkOutput($sformatf("starve_stall_if_%0d", i), 32'(bus.stall_if), 32'(!ifWin));
      checkOutput($sformatf("starve_stall_ls_%0d", i), 32'(bus.stall_ls), 32'(ifWin));
      if (i > 0) begin
        checkOutput($sformatf("starve_if_valid_%0d", i), 32'(bus.if_valid), 32'(prevIfWin));
        checkOutput($sformatf("starve_ls_valid_%0d", i), 32'(bus.ls_valid), 32'(!prevIfWin));
      end
      prevIfWin = ifWin;
    end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("starve_last_if_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("starve_last_if_rdata", bus.if_rdata, 32'h7FF);

    // Reset pulsed between the fetch grant edge and the valid cycle.
    nextCycle();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("midrst_if_gnt", 32'(bus.if_gnt), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rstN = 1'b0;
    #2;
    checkOutput("midrst_if_valid_in", 32'(bus.if_valid), 32'd0);
    rstN = 1'b1;
    #1;
    checkOutput("midrst_if_valid_rel", 32'(bus.if_valid), 32'd0);
    checkOutput("midrst_if_rdata_rel", bus.if_rdata, 32'd0);
    nextCycle();
    #2;
    checkOutput("midrst_if_valid_next", 32'(bus.if_valid), 32'd0);
    checkOutput("midrst_if_rdata_next", bus.if_rdata, 32'd0);

    // Alternating single requests: fetch, load, fetch.
    nextCycle();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("alt_a_if_gnt", 32'(bus.if_gnt), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    #2;
    checkOutput("alt_b_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    checkOutput("alt_b_if_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("alt_b_if_rdata", bus.if_rdata, 32'h7FF);
    checkOutput("alt_b_ls_valid", 32'(bus.ls_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("alt_c_if_gnt", 32'(bus.if_gnt), 32'd1);
    checkOutput("alt_c_ls_valid", 32'(bus.ls_valid), 32'd1);
    checkOutput("alt_c_ls_rdata", bus.ls_rdata, 32'h7FF);
    checkOutput("alt_c_if_valid", 32'(bus.if_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("alt_d_if_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("alt_d_ls_valid", 32'(bus.ls_valid), 32'd0);

    $display("[TB] %0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
